// File: rtl/spart_pkg.sv
// Shared constants and state encodings for the SPART serial port.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DBL    = 2'b10;
    localparam logic [1:0] ADDR_DBH    = 2'b11;

    localparam logic [15:0] DIV_RESET = 16'd651;

    localparam logic [15:0] DIV_4800  = 16'd651;
    localparam logic [15:0] DIV_9600  = 16'd326;
    localparam logic [15:0] DIV_19200 = 16'd163;
    localparam logic [15:0] DIV_38400 = 16'd81;

    typedef logic [0:0] tx_state_t;
    localparam tx_state_t TX_IDLE  = 1'b0;
    localparam tx_state_t TX_SHIFT = 1'b1;

    typedef logic [1:0] rx_state_t;
    localparam rx_state_t RX_IDLE  = 2'd0;
    localparam rx_state_t RX_START = 2'd1;
    localparam rx_state_t RX_DATA  = 2'd2;
    localparam rx_state_t RX_STOP  = 2'd3;

    // Divisor for each two-bit baud selection at 50 MHz.
    function automatic logic [15:0] br_cfg_divisor(input logic [1:0] br_cfg);
        case (br_cfg)
            2'd0:    return DIV_4800;
            2'd1:    return DIV_9600;
            2'd2:    return DIV_19200;
            default: return DIV_38400;
        endcase
    endfunction

endpackage

// File: rtl/spart_if.sv
// Driver-side register access signals plus FSM state taps for the SPART.
// Access protocol: an access is presented while iocs=1 for one cycle; iorw=1 reads
// (data valid combinationally that cycle), iorw=0 writes (captured at the clk edge).
interface spart_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;
    logic [0:0] tx_state;
    logic [1:0] rx_state;

    modport master (output iocs, iorw, ioaddr, input rda, tbr, tx_state, rx_state);
    modport slave  (input iocs, iorw, ioaddr, output rda, tbr, tx_state, rx_state);
endinterface

// File: rtl/spart_baud_gen.sv
// Programmable baud divisor: one-cycle en pulse every `divisor` clocks.
module spart_baud_gen #(
    parameter int               DIV_W     = 16,
    parameter logic [DIV_W-1:0] DIV_RESET = 16'd651
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_lo,
    input  logic       wr_hi,
    input  logic [7:0] wdata,
    output logic       en
);

    logic [DIV_W-1:0] divisor;
    logic [DIV_W-1:0] div_next;
    logic [DIV_W-1:0] cnt;

    // Divisors of 0 and 1 both collapse to a pulse on every cycle.
    function automatic logic [DIV_W-1:0] reload_val(input logic [DIV_W-1:0] d);
        return (d <= DIV_W'(1)) ? '0 : d - DIV_W'(1);
    endfunction

    always_comb begin
        div_next = divisor;
        if (wr_lo) div_next[7:0] = wdata;
        if (wr_hi) div_next[DIV_W-1:8] = wdata[DIV_W-9:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            divisor <= DIV_RESET;
            cnt     <= reload_val(DIV_RESET);
        end else begin
            divisor <= div_next;
            if (wr_lo || wr_hi || cnt == '0) cnt <= reload_val(div_next);
            else                             cnt <= cnt - DIV_W'(1);
        end
    end

    assign en = (cnt == '0);

endmodule

// File: rtl/spart.sv
// SPART top: register decode, double-buffered 8N1 transmitter and oversampling receiver.
module spart #(
    parameter int               DIV_W      = 16,
    parameter int               OVERSAMPLE = 16,
    parameter logic [DIV_W-1:0] DIV_RESET  = spart_pkg::DIV_RESET
) (
    input  logic      clk,
    input  logic      rst_n,
    spart_if.slave    bus,
    inout  wire [7:0] databus,
    output logic      txd,
    input  logic      rxd
);
    import spart_pkg::*;

    localparam int              OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

    logic       en;
    logic       wr, rd, tx_wr, rx_rd;
    logic [7:0] wdata, rdata;

    logic            tbr_q;
    tx_state_t       tx_state;
    logic [7:0]      tx_buf;
    logic [9:0]      tx_shreg;
    logic [3:0]      tx_bit;
    logic [OS_W-1:0] tx_os;

    logic            rda_q;
    rx_state_t       rx_state;
    logic            rxd_m, rxd_s;
    logic [7:0]      rx_shreg, rx_buf;
    logic [2:0]      rx_bit;
    logic [OS_W-1:0] rx_os;

    assign wr    = bus.iocs && !bus.iorw;
    assign rd    = bus.iocs && bus.iorw;
    assign tx_wr = wr && (bus.ioaddr == ADDR_DATA);
    assign rx_rd = rd && (bus.ioaddr == ADDR_DATA);
    assign wdata = databus;

    always_comb begin
        case (bus.ioaddr)
            ADDR_DATA:   rdata = rx_buf;
            ADDR_STATUS: rdata = {6'b0, tbr_q, rda_q};
            default:     rdata = 8'h00;
        endcase
    end

    assign databus = rd ? rdata : 8'bz;

    spart_baud_gen #(.DIV_W(DIV_W), .DIV_RESET(DIV_RESET)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_lo (wr && (bus.ioaddr == ADDR_DBL)),
        .wr_hi (wr && (bus.ioaddr == ADDR_DBH)),
        .wdata (wdata),
        .en    (en)
    );

    // tbr_q is the buffer-empty flag; a write and a buffer-to-shifter move never coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tbr_q    <= 1'b1;
            tx_buf   <= 8'h00;
            tx_shreg <= '1;
            tx_bit   <= 4'd0;
            tx_os    <= '0;
        end else begin
            if (tx_wr && tbr_q) begin
                tx_buf <= wdata;
                tbr_q  <= 1'b0;
            end
            if (tx_state == TX_IDLE) begin
                if (!tbr_q) begin
                    tx_shreg <= {1'b1, tx_buf, 1'b0};
                    tbr_q    <= 1'b1;
                    tx_state <= TX_SHIFT;
                    tx_bit   <= 4'd0;
                    tx_os    <= '0;
                end
            end else if (en) begin
                if (tx_os == OS_LAST) begin
                    tx_os <= '0;
                    if (tx_bit == 4'd9) begin
                        tx_bit <= 4'd0;
                        if (!tbr_q) begin
                            tx_shreg <= {1'b1, tx_buf, 1'b0};
                            tbr_q    <= 1'b1;
                        end else begin
                            tx_shreg <= '1;
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_shreg <= {1'b1, tx_shreg[9:1]};
                        tx_bit   <= tx_bit + 4'd1;
                    end
                end else begin
                    tx_os <= tx_os + OS_W'(1);
                end
            end
        end
    end

    assign txd = tx_shreg[0];

    // A completed byte takes priority over a same-cycle read clearing rda.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_m    <= 1'b1;
            rxd_s    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_shreg <= 8'h00;
            rx_buf   <= 8'h00;
            rx_bit   <= 3'd0;
            rx_os    <= '0;
            rda_q    <= 1'b0;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            if (rx_rd) rda_q <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rxd_s) begin
                        rx_state <= RX_START;
                        rx_os    <= '0;
                    end
                end
                RX_START: begin
                    if (en) begin
                        if (rx_os == OS_HALF) begin
                            rx_os    <= '0;
                            rx_bit   <= 3'd0;
                            rx_state <= rxd_s ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_os <= rx_os + OS_W'(1);
                        end
                    end
                end
                RX_DATA: begin
                    if (en) begin
                        if (rx_os == OS_LAST) begin
                            rx_os    <= '0;
                            rx_shreg <= {rxd_s, rx_shreg[7:1]};
                            if (rx_bit == 3'd7) rx_state <= RX_STOP;
                            else                rx_bit   <= rx_bit + 3'd1;
                        end else begin
                            rx_os <= rx_os + OS_W'(1);
                        end
                    end
                end
                default: begin
                    if (en) begin
                        if (rx_os == OS_LAST) begin
                            rx_os    <= '0;
                            rx_state <= RX_IDLE;
                            if (rxd_s) begin
                                rx_buf <= rx_shreg;
                                rda_q  <= 1'b1;
                            end
                        end else begin
                            rx_os <= rx_os + OS_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.rda      = rda_q;
    assign bus.tbr      = tbr_q;
    assign bus.tx_state = tx_state;
    assign bus.rx_state = rx_state;

endmodule

// File: tb/tb_spart.sv
// Directed bench for the SPART: register map, TX/RX framing, glitch, framing error, overrun, loopback.
module tb_spart;
    import spart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    wire  [7:0] databus;
    logic       drv_en = 1'b0;
    logic [7:0] drv_val = 8'h00;
    logic       txd;
    logic       rxd;
    logic       rxd_drv = 1'b1;
    logic       loop_en = 1'b0;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         rda_rise = 0;
    logic       rda_d = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign databus = drv_en ? drv_val : 8'bz;
    assign rxd     = loop_en ? txd : rxd_drv;

    spart_if bus ();

    spart dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .databus (databus),
        .txd     (txd),
        .rxd     (rxd)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rda && !rda_d) rda_rise <= cyc;
        rda_d <= bus.rda;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a;
        drv_val = d; drv_en = 1'b1;
        @(negedge clk);
        bus.iocs = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
        #1 d = databus;
        @(negedge clk);
        bus.iocs = 1'b0; bus.iorw = 1'b0;
    endtask

    // A zero stop bit is held for 3/4 of a bit so the receiver's re-armed start
    // detection samples the line already back high.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int bitc, output int t0);
        @(negedge clk);
        rxd_drv = 1'b0;
        t0 = cyc;
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = d[i];
            repeat (bitc) @(negedge clk);
        end
        rxd_drv = stop;
        repeat (stop ? bitc : (bitc * 3) / 4) @(negedge clk);
        rxd_drv = 1'b1;
    endtask

    task automatic wait_rda(input int max_cyc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            if (bus.rda) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       ok;
        int         t0;

        bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_tbr", bus.tbr, 1'b1);
        check("rst_rda", bus.rda, 1'b0);
        check("rst_tx_state", bus.tx_state, TX_IDLE);
        check("rst_rx_state", bus.rx_state, RX_IDLE);
        rst_n = 1'b1;

        bus_read(ADDR_STATUS, rd);
        check("rst_status", rd, 8'h02);
        bus_read(ADDR_DBL, rd);
        check("read_dbl_zero", rd, 8'h00);
        bus_read(ADDR_DBH, rd);
        check("read_dbh_zero", rd, 8'h00);

        @(negedge clk);
        bus.iorw = 1'b1; drv_val = 8'h5A; drv_en = 1'b1;
        #1 check("bus_released", databus, 8'h5A);
        drv_en = 1'b0; bus.iorw = 1'b0;

        bus_write(ADDR_STATUS, 8'hFF);
        bus_read(ADDR_STATUS, rd);
        check("status_write_ignored", rd, 8'h02);

        bus_write(ADDR_DBL, 8'h51);
        bus_write(ADDR_DBH, 8'h00);

        fork
            begin
                logic [9:0] fr;
                fr = {1'b1, 8'hA5, 1'b0};
                bus_write(ADDR_DATA, 8'hA5);
                check("tx_tbr_full", bus.tbr, 1'b0);
                @(negedge clk);
                check("tx_tbr_freed", bus.tbr, 1'b1);
                check("tx_state_shift", bus.tx_state, TX_SHIFT);
                repeat (648) @(negedge clk);
                for (int k = 0; k < 10; k++) begin
                    check($sformatf("tx_a5_bit%0d", k), txd, fr[k]);
                    repeat (1296) @(negedge clk);
                end
                check("tx_done_idle", bus.tx_state, TX_IDLE);
                check("tx_done_txd", txd, 1'b1);
            end
            begin
                logic [7:0] rd2;
                int         lat;
                int         ft0;
                send_frame(8'h3C, 1'b1, 1296, ft0);
                check("rx3c_rda", bus.rda, 1'b1);
                lat = rda_rise - ft0;
                check("rx3c_latency_window", (lat >= 12200 && lat <= 12350), 1'b1);
                bus_read(ADDR_DATA, rd2);
                check("rx3c_data", rd2, 8'h3C);
                check("rx3c_rda_clear", bus.rda, 1'b0);
            end
        join

        @(negedge clk);
        rxd_drv = 1'b0;
        repeat (300) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (400) @(negedge clk);
        check("glitch_rx_idle", bus.rx_state, RX_IDLE);
        check("glitch_rda", bus.rda, 1'b0);
        send_frame(8'h55, 1'b1, 1296, t0);
        check("rx55_rda", bus.rda, 1'b1);
        bus_read(ADDR_DATA, rd);
        check("rx55_data", rd, 8'h55);

        bus_write(ADDR_DBL, 8'h04);
        send_frame(8'h12, 1'b0, 64, t0);
        repeat (128) @(negedge clk);
        check("framing_rda", bus.rda, 1'b0);
        check("framing_rx_idle", bus.rx_state, RX_IDLE);
        send_frame(8'h11, 1'b1, 64, t0);
        send_frame(8'h22, 1'b1, 64, t0);
        bus_read(ADDR_STATUS, rd);
        check("overrun_status", rd, 8'h03);
        bus_read(ADDR_DATA, rd);
        check("overrun_data", rd, 8'h22);
        check("overrun_rda_clear", bus.rda, 1'b0);

        bus_write(ADDR_DBL, 8'hA3);
        loop_en = 1'b1;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        bus_write(ADDR_DATA, 8'h01);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (bus.tbr) ok = 1'b1;
            else @(negedge clk);
        end
        check("lb_tbr_freed", ok, 1'b1);
        bus_write(ADDR_DATA, 8'h02);
        check("lb_tbr_full", bus.tbr, 1'b0);
        bus_write(ADDR_DATA, 8'hFF);
        check("lb_tbr_still_full", bus.tbr, 1'b0);
        for (int n = 0; n < 2; n++) begin
            wait_rda(30000, ok);
            check($sformatf("lb_rda_%0d", n), ok, 1'b1);
            bus_read(ADDR_DATA, rd);
            check($sformatf("lb_data_%0d", n), rd, exp_q.pop_front());
        end
        repeat (5216) @(negedge clk);
        check("lb_tx_idle", bus.tx_state, TX_IDLE);
        check("lb_tbr_empty", bus.tbr, 1'b1);
        check("lb_no_extra_byte", bus.rda, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
